rf_read_streamer: RTL
=====================

Name: rf_read_streamer

Overview:
- Read-side master for the RegFile register bank; companion to the write path.
- On a start command it sweeps a contiguous window of RegFile addresses through the rd/AddrRd port, one word per access.
- It captures each returned word and presents it on a valid/ready output stream with its address and a last flag.
- Used for memory dump, checksum, and bank-copy paths.

Parameters:
- WS, 4, RegFile word size in bits.
- DEPTH, 8, number of RegFile entries.
- AS, $clog2(DEPTH), address width.

Ports:
- clk  input  1  master clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- start  input  1  one-cycle command pulse; honoured only in IDLE.
- base_addr  input  AS  first address of the window; sampled with start.
- count  input  AS+1  words to read; sampled with start; 0 is treated as DEPTH.
- abort  input  1  synchronous cancel of the current sweep.
- busy  output  1  high from the cycle after start is accepted until the return to IDLE.
- done  output  1  one-cycle pulse after the last word is accepted downstream.
- rf_rd  output  1  RegFile read strobe.
- rf_addr_rd  output  AS  RegFile read address.
- rf_data_rd  input  WS  RegFile read data, valid while rf_rd=1.
- out_valid  output  1  stream word valid.
- out_ready  input  1  downstream accept.
- out_data  output  WS  captured word.
- out_addr  output  AS  address the word came from.
- out_last  output  1  marks the final word of the sweep.

Behaviour:
- Reset values: all outputs 0; state IDLE; internal address and remaining-count registers 0.
- FSM states: IDLE, READ, HOLD, DONE. All outputs are registered or decoded from state only; no combinational path from out_ready to any output.
- IDLE:
  - start=1 latches base_addr into cur_addr.
  - It latches remaining = (count==0 ? DEPTH : count).
  - Transition to READ.
- READ (exactly one cycle):
  - rf_rd=1 and rf_addr_rd=cur_addr for the whole cycle.
  - At the closing rising edge: out_data<=rf_data_rd, out_addr<=cur_addr, out_last<=(remaining==1), out_valid<=1, remaining<=remaining-1.
  - Transition to HOLD.
- HOLD:
  - rf_rd=0 and rf_addr_rd=0.
  - out_data, out_addr and out_last hold stable while out_valid=1 and out_ready=0.
  - On out_valid and out_ready: out_valid<=0.
  - If out_last was set, transition to DONE.
  - Otherwise cur_addr<=(cur_addr==DEPTH-1) ? 0 : cur_addr+1, then transition to READ.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in READ, HOLD and DONE.
- Timing:
  - Latency from start to the first out_valid is 2 cycles.
  - Peak throughput is 1 word per 2 cycles, with out_ready held high.
- Address wrap: modulo DEPTH. This is correct for non-power-of-2 DEPTH.
- A start pulse in any state other than IDLE is ignored. There is no queuing.
- abort:
  - Any state goes to IDLE on the next edge; out_valid<=0; no done pulse.
  - abort has priority over a simultaneous handshake.
- If out_ready arrives in the same cycle out_valid rises, the word is not accepted. Acceptance requires out_valid=1 sampled at the edge.
- Reset asserted mid-sweep clears everything immediately (asynchronous). No partial output is preserved.
- rf_rd is never high for two consecutive cycles, and never high outside READ.

Decomposition:
- Shared package bus_definitions gets:
  - typedef enum logic [1:0] rf_stream_state_t {IDLE, READ, HOLD, DONE};
  - typedef struct packed {data, addr, last} rf_stream_word_t, parameterized via WS/AS localparams.
- One natural sub-module, rf_addr_seq:
  - Holds the cur_addr and remaining registers.
  - Provides load, step (wrap), and is_last.
  - The top level keeps the FSM and the output register.

Test Plan (DEPTH=8, WS=4; RegFile preloaded with mem[i]=i+3):
- Basic sweep: start, base=2, count=3, out_ready=1 -> out_data 5,6,7 at out_addr 2,3,4; out_last only on addr 4; done pulses once; rf_rd high 3 cycles total.
- Wrap: base=6, count=4 -> out_addr 6,7,0,1; out_data 9,A,3,4; last on addr 1.
- Count=0: base=0, count=0 -> 8 words, data 3..A, out_last on addr 7; busy deasserts after done.
- Backpressure: out_ready low for 5 cycles on the 2nd word -> out_data/out_addr stable throughout; rf_rd stays 0 during the stall; no word lost or duplicated.
- Abort and busy-start: abort in HOLD of word 2 -> out_valid=0 and busy=0 next cycle, no done; a start pulse issued while busy -> ignored, verified by word count.
- Reset mid-sweep: drive reset=0 during READ -> all outputs 0 asynchronously; after reset=1, a fresh start base=5, count=1 returns data 8 with last=1.

Source files
------------

// File: rtl/bus_definitions.sv
// Shared types for the RegFile read-stream path: sweep FSM states and the
// word/address/last record that travels on the output stream.
package bus_definitions;

  localparam int RF_WS    = 4;
  localparam int RF_DEPTH = 8;
  localparam int RF_AS    = $clog2(RF_DEPTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    HOLD = 2'd2,
    DONE = 2'd3
  } rf_stream_state_t;

  typedef struct packed {
    logic [RF_WS-1:0] data;
    logic [RF_AS-1:0] addr;
    logic             last;
  } rf_stream_word_t;

endpackage

// File: rtl/rf_read_streamer_addr_seq.sv
// Window walker: current RegFile address (wrapping modulo DEPTH) and the
// number of words still to be read in the sweep.
module rf_addr_seq #(
  parameter int DEPTH = 8,
  parameter int AS    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          clear,
  input  logic          load,
  input  logic          dec,
  input  logic          step,
  input  logic [AS-1:0] load_addr,
  input  logic [AS:0]   load_count,
  output logic [AS-1:0] cur_addr,
  output logic          is_last
);

  localparam logic [AS:0]   FULL_COUNT = (AS+1)'(DEPTH);
  localparam logic [AS:0]   ONE_COUNT  = (AS+1)'(1);
  localparam logic [AS-1:0] TOP_ADDR   = AS'(DEPTH-1);
  localparam logic [AS-1:0] ONE_ADDR   = AS'(1);

  logic [AS:0] remaining;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (clear) begin
      cur_addr  <= '0;
      remaining <= '0;
    end else if (load) begin
      cur_addr  <= load_addr;
      // A zero count means a full-bank sweep.
      remaining <= (load_count == '0) ? FULL_COUNT : load_count;
    end else begin
      if (dec) remaining <= remaining - ONE_COUNT;
      // Explicit compare keeps the wrap correct for non-power-of-2 depths.
      if (step) cur_addr <= (cur_addr == TOP_ADDR) ? '0 : cur_addr + ONE_ADDR;
    end
  end

  assign is_last = (remaining == ONE_COUNT);

endmodule

// File: rtl/rf_read_streamer.sv
// Sweeps a window of RegFile addresses, one read per word, and presents each
// captured word on a valid/ready stream tagged with its address and a last flag.
//
// state | meaning
// IDLE  | waiting for start; stream empty
// READ  | rf_rd asserted for one cycle, word captured at the closing edge
// HOLD  | word presented on the stream until accepted downstream
// DONE  | one-cycle done pulse after the final word was accepted
module rf_read_streamer
  import bus_definitions::*;
#(
  parameter int WS    = RF_WS,
  parameter int DEPTH = RF_DEPTH,
  parameter int AS    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AS-1:0] base_addr,
  input  logic [AS:0]   count,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          rf_rd,
  output logic [AS-1:0] rf_addr_rd,
  input  logic [WS-1:0] rf_data_rd,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [WS-1:0] out_data,
  output logic [AS-1:0] out_addr,
  output logic          out_last
);

  rf_stream_state_t state;
  logic [AS-1:0]    cur_addr;
  logic             is_last;
  logic             accept;
  logic             seq_load;
  logic             seq_dec;
  logic             seq_step;

  // Acceptance uses only registered out_valid, so out_ready never reaches an output.
  assign accept   = (state == HOLD) && out_valid && out_ready;
  assign seq_load = (state == IDLE) && start && !abort;
  assign seq_dec  = (state == READ) && !abort;
  assign seq_step = accept && !out_last && !abort;

  rf_addr_seq #(
    .DEPTH (DEPTH),
    .AS    (AS)
  ) u_addr_seq (
    .clk        (clk),
    .reset      (reset),
    .clear      (abort),
    .load       (seq_load),
    .dec        (seq_dec),
    .step       (seq_step),
    .load_addr  (base_addr),
    .load_count (count),
    .cur_addr   (cur_addr),
    .is_last    (is_last)
  );

  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign rf_rd      = (state == READ);
  assign rf_addr_rd = (state == READ) ? cur_addr : '0;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_addr  <= '0;
      out_last  <= 1'b0;
    end else if (abort) begin
      state     <= IDLE;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) state <= READ;
        READ: begin
          out_data  <= rf_data_rd;
          out_addr  <= cur_addr;
          out_last  <= is_last;
          out_valid <= 1'b1;
          state     <= HOLD;
        end
        HOLD: if (accept) begin
          out_valid <= 1'b0;
          state     <= out_last ? DONE : READ;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule
